// File: rtl/shift_sequencer_if.sv
// Handshake bundle between the ALU dispatcher, the shift sequencer and the result bus.
// The slave modport is the sequencer's view; master is the dispatcher/consumer side.
interface shift_sequencer_if #(
  parameter int N = 8
);
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_out;
  logic         o_ovf;
  logic         o_ERR;
  logic         o_busy;

  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_out, o_ovf, o_ERR, o_busy
  );

  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_out, o_ovf, o_ERR, o_busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Bit-serial sign-magnitude left shifter: one magnitude shift per cycle, early stop on zero,
// with valid/ready hand-shakes on both the operand and the result side.
module shift_sequencer #(
  parameter int N = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [N-2:0] ONE = {{(N-2){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic         sign_q, sign_d;
  logic [N-2:0] mag_q, mag_d;
  logic [N-2:0] cnt_q, cnt_d;
  logic         acc_ovf_q, acc_ovf_d;
  logic [N-1:0] out_q, out_d;
  logic         ovf_q, ovf_d;
  logic         err_q, err_d;
  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;
  logic [N-2:0] shifted_mag;
  logic         shifted_ovf;

  assign shifted_mag = {mag_q[N-3:0], 1'b0};
  assign shifted_ovf = acc_ovf_q | mag_q[N-2];

  // Result registers only change when a result is produced, so they stay stable through SHIFT and IDLE.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    acc_ovf_d = acc_ovf_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          sign_d    = bus.i_a[N-1];
          mag_d     = bus.i_a[N-2:0];
          cnt_d     = bus.i_b[N-2:0];
          acc_ovf_d = 1'b0;
          if (bus.i_b[N-1]) begin
            out_d   = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = DONE;
          end else if (bus.i_b[N-2:0] == '0 || bus.i_a[N-2:0] == '0) begin
            out_d   = bus.i_a;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mag_d     = shifted_mag;
        cnt_d     = cnt_q - ONE;
        acc_ovf_d = shifted_ovf;
        if (cnt_q == ONE || shifted_mag == '0) begin
          out_d   = {sign_q, shifted_mag};
          ovf_d   = shifted_ovf;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      cnt_q     <= '0;
      acc_ovf_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      acc_ovf_q <= acc_ovf_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_out   = out_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_ERR   = err_q;
  assign bus.o_busy  = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against an arithmetic model of the
// sign-magnitude shift (result, overflow, error flag and hand-off latency).
module tb_shift_sequencer;

  localparam int N = 8;
  localparam int MAX_WAIT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total_count = 0;
  int   pass_count  = 0;
  int   fail_count  = 0;

  shift_sequencer_if #(.N(N)) bus ();

  shift_sequencer #(.N(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Expected behaviour from the arithmetic definition: k = min(|B|, Z) doublings of the magnitude.
  task automatic referenceModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] out, output logic ovf,
                                output logic err, output int k);
    int mag, z, prod, bmag;
    mag  = int'(a[N-2:0]);
    bmag = int'(b[N-2:0]);
    if (b[N-1]) begin
      out = '0; ovf = 1'b0; err = 1'b1; k = 0;
    end else begin
      z = 0;
      if (mag != 0) begin
        int low;
        low = 0;
        while (((mag >> low) & 1) == 0) low++;
        z = (N - 1) - low;
      end
      k    = (bmag < z) ? bmag : z;
      prod = mag * (1 << k);
      out  = {a[N-1], prod[N-2:0]};
      ovf  = (prod >= (1 << (N - 1)));
      err  = 1'b0;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkValue({tag, " o_ready"}, 32'(bus.o_ready), 32'd1);
    checkValue({tag, " o_valid"}, 32'(bus.o_valid), 32'd0);
    checkValue({tag, " o_out"},   32'(bus.o_out),   32'd0);
    checkValue({tag, " o_ovf"},   32'(bus.o_ovf),   32'd0);
    checkValue({tag, " o_ERR"},   32'(bus.o_ERR),   32'd0);
    checkValue({tag, " o_busy"},  32'(bus.o_busy),  32'd0);
  endtask

  // Accepts one operand pair, scrambles the inputs afterwards, and waits (bounded) for o_valid.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               output int latency, output logic busy_dropped);
    int waited;
    waited = 0;
    while (!bus.o_ready && waited < MAX_WAIT) begin
      @(posedge clk); #1; waited++;
    end
    checkValue("ready before accept", 32'(bus.o_ready), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_a     = N'($urandom);
    bus.i_b     = N'($urandom);
    latency      = 0;
    busy_dropped = 1'b0;
    while (!bus.o_valid && latency < MAX_WAIT) begin
      if (bus.o_busy !== 1'b1) busy_dropped = 1'b1;
      @(posedge clk); #1; latency++;
    end
    if (bus.o_busy !== 1'b1) busy_dropped = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                             input int latency, input logic busy_dropped);
    logic [N-1:0] exp_out;
    logic         exp_ovf, exp_err;
    int           exp_k;
    referenceModel(a, b, exp_out, exp_ovf, exp_err, exp_k);
    checkValue({tag, " o_valid"}, 32'(bus.o_valid), 32'd1);
    checkValue({tag, " o_out"},   32'(bus.o_out),   32'(exp_out));
    checkValue({tag, " o_ovf"},   32'(bus.o_ovf),   32'(exp_ovf));
    checkValue({tag, " o_ERR"},   32'(bus.o_ERR),   32'(exp_err));
    checkValue({tag, " latency"}, 32'(latency),     32'(exp_k));
    checkValue({tag, " busy"},    32'(busy_dropped), 32'd0);
  endtask

  task automatic releaseResult(input string tag, input int delay);
    logic [N-1:0] held_out;
    held_out = bus.o_out;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    checkValue({tag, " valid drops"}, 32'(bus.o_valid), 32'd0);
    checkValue({tag, " ready back"},  32'(bus.o_ready), 32'd1);
    checkValue({tag, " out kept"},    32'(bus.o_out),   32'(held_out));
  endtask

  task automatic runTransaction(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                                input int delay);
    int   latency;
    logic busy_dropped;
    applyStimulus(a, b, latency, busy_dropped);
    checkOutput(tag, a, b, latency, busy_dropped);
    releaseResult(tag, delay);
  endtask

  initial begin
    int           latency;
    logic         busy_dropped;
    logic [N-1:0] held_out;
    logic         held_ovf, held_err;
    logic [N-1:0] ra, rb;

    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_ready = 1'b0;
    rst         = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkReset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    runTransaction("t1 05<<2",   8'h05, 8'h02, 0);
    runTransaction("t2 85<<3",   8'h85, 8'h03, 1);
    runTransaction("t3 41<<1",   8'h41, 8'h01, 0);
    runTransaction("t4 err",     8'h5A, 8'h83, 0);
    runTransaction("t4 -0",      8'h80, 8'h05, 0);
    runTransaction("t5 01<<127", 8'h01, 8'h7F, 0);
    runTransaction("b zero",     8'h33, 8'h00, 0);
    runTransaction("ovf full",   8'h7F, 8'h07, 0);

    // Result held in DONE while new operands are offered and must be ignored.
    applyStimulus(8'h05, 8'h02, latency, busy_dropped);
    checkOutput("t6 hold", 8'h05, 8'h02, latency, busy_dropped);
    held_out = bus.o_out;
    held_ovf = bus.o_ovf;
    held_err = bus.o_ERR;
    for (int i = 0; i < 3; i++) begin
      bus.i_valid = 1'b1;
      bus.i_a     = 8'hC3;
      bus.i_b     = 8'h81;
      @(posedge clk); #1;
      checkValue("t6 hold valid", 32'(bus.o_valid), 32'd1);
      checkValue("t6 hold ready", 32'(bus.o_ready), 32'd0);
      checkValue("t6 hold out",   32'(bus.o_out),   32'(held_out));
      checkValue("t6 hold ovf",   32'(bus.o_ovf),   32'(held_ovf));
      checkValue("t6 hold err",   32'(bus.o_ERR),   32'(held_err));
    end
    bus.i_valid = 1'b0;
    releaseResult("t6 hold", 0);

    // Reset in the middle of a long shift discards the operation.
    bus.i_valid = 1'b1;
    bus.i_a     = 8'h01;
    bus.i_b     = 8'h7F;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkValue("t6 busy mid shift", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkReset("t6 mid reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkValue("t6 no valid after reset", 32'(bus.o_valid), 32'd0);
    end

    for (int n = 0; n < 40; n++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if ($urandom_range(0, 3) != 0) rb[N-1] = 1'b0;
      if ($urandom_range(0, 1) == 0) rb[N-2:0] = N'($urandom_range(0, 9));
      runTransaction($sformatf("rand%0d a=%0h b=%0h", n, ra, rb), ra, rb, $urandom_range(0, 2));
    end

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
